// File: rtl/fetch_sequencer_pkg.sv
// Shared CPU defines for the fetch front end.
// Holds the default data/address widths, the reset vector location, the
// fetch sequencer state encoding and the operand-length rule used to decide
// how many operand bytes follow an opcode.
package fetch_sequencer_pkg;

    localparam int REG_WIDTH_DEF  = 8;
    localparam int ADDR_WIDTH_DEF = 16;

    // Low byte of the reset vector; the high byte lives at the next address.
    localparam logic [15:0] RESET_VECTOR_DEF = 16'hFFFC;

    typedef enum logic [2:0] {
        VEC_LO    = 3'd0,
        VEC_HI    = 3'd1,
        IDLE      = 3'd2,
        FETCH_OP  = 3'd3,
        FETCH_LO  = 3'd4,
        FETCH_HI  = 3'd5,
        WAIT_DONE = 3'd6
    } fetch_state_t;

    // Number of operand bytes that follow an opcode laid out as {aaa,bbb,cc}.
    // BRK/RTI/RTS carry no operand even though their group would suggest one,
    // and JSR always carries an absolute address.
    function automatic logic [1:0] operand_length(input logic [7:0] opcode);
        logic [2:0] bbb;
        logic [1:0] cc;
        logic [1:0] len;
        bbb = opcode[4:2];
        cc  = opcode[1:0];
        len = 2'd1;
        if (opcode == 8'h00 || opcode == 8'h40 || opcode == 8'h60) begin
            len = 2'd0;
        end else if (opcode == 8'h20) begin
            len = 2'd2;
        end else begin
            case (cc)
                2'b01: begin
                    if (bbb == 3'b011 || bbb == 3'b110 || bbb == 3'b111) len = 2'd2;
                    else                                                 len = 2'd1;
                end
                2'b10, 2'b00: begin
                    if (bbb == 3'b010 || bbb == 3'b110)      len = 2'd0;
                    else if (bbb == 3'b011 || bbb == 3'b111) len = 2'd2;
                    else                                     len = 2'd1;
                end
                default: len = 2'd0;
            endcase
        end
        return len;
    endfunction

endpackage

// File: rtl/fetch_sequencer_oplen_decode.sv
// Combinational operand-length decoder.
// Ports:
//   opcode  in   8  opcode byte to classify
//   length  out  2  number of operand bytes that follow (0, 1 or 2)
module oplen_decode
    import fetch_sequencer_pkg::*;
(
    input  logic [7:0] opcode,
    output logic [1:0] length
);

    assign length = operand_length(opcode);

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer.
// After reset it reads the two-byte reset vector into pc, then repeatedly
// fetches an opcode plus its 0, 1 or 2 operand bytes, presents them to the
// decoder and waits for the decoder to finish before fetching again.
// Ports:
//   clk                in   rising-edge clock
//   reset              in   asynchronous active-high reset
//   run                in   allows a new fetch to start from IDLE
//   mem_addr           out  read address
//   mem_rd             out  read request, held until mem_valid
//   mem_rdata          in   read data
//   mem_valid          in   completes the current read
//   instruction_out    out  fetched opcode
//   addr_out           out  assembled operand / effective base address
//   instruction_ready  out  opcode and operand valid for the decoder
//   instruction_done   in   decoder finished the current instruction
//   pc_load            in   redirect request (IDLE / WAIT_DONE only)
//   pc_load_val        in   redirect target
//   pc                 out  current program counter
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int                    REG_WIDTH    = REG_WIDTH_DEF,
    parameter int                    ADDR_WIDTH   = ADDR_WIDTH_DEF,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = RESET_VECTOR_DEF
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd,
    input  logic [REG_WIDTH-1:0]  mem_rdata,
    input  logic                  mem_valid,
    output logic [REG_WIDTH-1:0]  instruction_out,
    output logic [ADDR_WIDTH-1:0] addr_out,
    output logic                  instruction_ready,
    input  logic                  instruction_done,
    input  logic                  pc_load,
    input  logic [ADDR_WIDTH-1:0] pc_load_val,
    output logic [ADDR_WIDTH-1:0] pc
);

    fetch_state_t          state;
    fetch_state_t          next_state;
    logic                  started;
    logic                  read_state;
    logic                  read_done;
    logic [REG_WIDTH-1:0]  vec_lo;
    logic [REG_WIDTH-1:0]  decode_opcode;
    logic [1:0]            op_len;

    // mem_rd must be low while reset is held even though the state already
    // sits in VEC_LO; 'started' keeps the request off until the first edge
    // after release, which also stops a late mem_valid from being captured.
    assign read_state = (state == VEC_LO)   || (state == VEC_HI)   ||
                        (state == FETCH_OP) || (state == FETCH_LO) ||
                        (state == FETCH_HI);
    assign mem_rd     = started && read_state;
    assign read_done  = mem_rd && mem_valid;

    // During FETCH_OP the length must come from the byte being returned;
    // afterwards the captured opcode is the source.
    assign decode_opcode = (state == FETCH_OP) ? mem_rdata : instruction_out;

    oplen_decode u_oplen_decode (
        .opcode (decode_opcode[7:0]),
        .length (op_len)
    );

    always_comb begin
        mem_addr = pc;
        case (state)
            VEC_LO:  mem_addr = RESET_VECTOR;
            VEC_HI:  mem_addr = RESET_VECTOR + ADDR_WIDTH'(1);
            default: mem_addr = pc;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= VEC_LO;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            VEC_LO:    if (read_done) next_state = VEC_HI;
            VEC_HI:    if (read_done) next_state = IDLE;
            IDLE:      if (run)       next_state = FETCH_OP;
            FETCH_OP:  if (read_done) next_state = (op_len == 2'd0) ? WAIT_DONE : FETCH_LO;
            FETCH_LO:  if (read_done) next_state = (op_len == 2'd2) ? FETCH_HI : WAIT_DONE;
            FETCH_HI:  if (read_done) next_state = WAIT_DONE;
            WAIT_DONE: if (instruction_done) next_state = IDLE;
            default:   next_state = VEC_LO;
        endcase
    end

    // Datapath registers. instruction_ready is set on the same edge that
    // enters WAIT_DONE so it is high for the whole of that state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            started           <= 1'b0;
            pc                <= '0;
            vec_lo            <= '0;
            instruction_out   <= '0;
            addr_out          <= '0;
            instruction_ready <= 1'b0;
        end else begin
            started <= 1'b1;
            case (state)
                VEC_LO: begin
                    if (read_done) vec_lo <= mem_rdata;
                end
                VEC_HI: begin
                    if (read_done) pc <= {mem_rdata, vec_lo};
                end
                IDLE: begin
                    if (pc_load) pc <= pc_load_val;
                end
                FETCH_OP: begin
                    if (read_done) begin
                        instruction_out <= mem_rdata;
                        addr_out        <= '0;
                        pc              <= pc + ADDR_WIDTH'(1);
                        if (op_len == 2'd0) instruction_ready <= 1'b1;
                    end
                end
                FETCH_LO: begin
                    if (read_done) begin
                        addr_out <= {{(ADDR_WIDTH-REG_WIDTH){1'b0}}, mem_rdata};
                        pc       <= pc + ADDR_WIDTH'(1);
                        if (op_len != 2'd2) instruction_ready <= 1'b1;
                    end
                end
                FETCH_HI: begin
                    if (read_done) begin
                        addr_out[ADDR_WIDTH-1:REG_WIDTH] <= mem_rdata;
                        pc                               <= pc + ADDR_WIDTH'(1);
                        instruction_ready                <= 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (pc_load)          pc                <= pc_load_val;
                    if (instruction_done) instruction_ready <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameters: REG_WIDTH default `REG_WIDTH (8), data byte width; ADDR_WIDTH default `ADDR_WIDTH (16), address width; RESET_VECTOR default 16'hFFFC, low-byte address of the reset vector.
REQ-002 The block SHALL use one clock and an asynchronous, active-high reset; the ports are named clk and reset.
REQ-003 Ports (name, direction, width, meaning):
- clk  in  1  rising-edge clock
- reset  in  1  async active-high reset
- run  in  1  enables fetching; when low, no new fetch is started
- mem_addr  out  ADDR_WIDTH  read address
- mem_rd  out  1  read request, held until accepted
- mem_rdata  in  REG_WIDTH  read data
- mem_valid  in  1  mem_rdata valid; completes the current read
- instruction_out  out  REG_WIDTH  fetched opcode
- addr_out  out  ADDR_WIDTH  assembled operand/effective base address
- instruction_ready  out  1  opcode and operand are valid for the decoder
- instruction_done  in  1  decoder has finished the current instruction
- pc_load  in  1  redirect request
- pc_load_val  in  ADDR_WIDTH  redirect target
- pc  out  ADDR_WIDTH  current program counter

Function
REQ-004 States SHALL be VEC_LO, VEC_HI, IDLE, FETCH_OP, FETCH_LO, FETCH_HI, WAIT_DONE.
REQ-005 VEC_LO: read RESET_VECTOR; VEC_HI: read RESET_VECTOR+1; pc <= {hi,lo} on the VEC_HI completion, then go to IDLE.
REQ-006 IDLE: if run=1, go to FETCH_OP next cycle; otherwise hold.
REQ-007 Each read state SHALL drive mem_rd=1 with mem_addr stable until the cycle mem_valid=1; data SHALL be captured on that edge. mem_valid outside a read state SHALL be ignored.
REQ-008 FETCH_OP reads at pc; on completion: instruction_out <= mem_rdata, pc <= pc+1, next state from operand length: 0 -> WAIT_DONE, 1 or 2 -> FETCH_LO.
REQ-009 Operand length from opcode {aaa,bbb,cc}: opcodes 8'h00, 8'h40, 8'h60 -> 0; 8'h20 -> 2; otherwise cc=01: bbb 011/110/111 -> 2, else 1; cc=10 or 00: bbb 010/110 -> 0, 011/111 -> 2, else 1; cc=11 -> 0.
REQ-010 FETCH_LO reads at pc; on completion: addr_out <= {8'h00, mem_rdata}, pc <= pc+1; length 1 -> WAIT_DONE, length 2 -> FETCH_HI.
REQ-011 FETCH_HI reads at pc; on completion: addr_out[15:8] <= mem_rdata, pc <= pc+1, go to WAIT_DONE.
REQ-012 Length-0 instructions SHALL present addr_out = 16'h0000.
REQ-013 WAIT_DONE: instruction_ready=1 (registered, asserted the cycle the state is entered); on instruction_done=1 deassert next cycle and go to IDLE. instruction_done in any other state SHALL be ignored.
REQ-014 pc_load=1 in IDLE or WAIT_DONE SHALL set pc <= pc_load_val; if pc_load and instruction_done coincide in WAIT_DONE, both take effect (load then IDLE). pc_load in any other state SHALL be ignored.
REQ-015 pc increments SHALL wrap 16'hFFFF -> 16'h0000.
REQ-016 run=0 SHALL not abort an in-progress fetch; it only blocks the IDLE -> FETCH_OP transition.

Reset
REQ-017 On reset assertion, immediately: state=VEC_LO, pc=16'h0000, mem_rd=0, instruction_ready=0, instruction_out=8'h00, addr_out=16'h0000; mem_addr follows state (RESET_VECTOR after reset).
REQ-018 Reset mid-read SHALL abandon the read; a late mem_valid SHALL NOT be captured.
REQ-019 After reset release, the vector fetch SHALL start on the first clk edge regardless of run.

Structure
REQ-020 State encoding, operand-length function and RESET_VECTOR default SHALL live in the shared CPU defines package alongside the existing `OPP_/`AM3_ constants.
REQ-021 Operand-length decode SHALL be a sub-module, oplen_decode (combinational, opcode in, 2-bit length out); everything else is in fetch_sequencer.

Verification
REQ-022 Vector: mem[FFFC]=34, mem[FFFD]=12, zero-wait memory -> pc=16'h1234 before the first FETCH_OP; first mem_addr=16'h1234.
REQ-023 Absolute: mem[1234..1236]=AD,00,20 -> instruction_out=AD, addr_out=16'h2000, instruction_ready=1, pc=16'h1237.
REQ-024 Zero-page with 3-cycle mem_valid delay per read: mem=A5,10 -> mem_addr held each wait cycle; addr_out=16'h0010; pc advances by 2.
REQ-025 Implied: opcode EA -> no operand read, addr_out=0000, ready; instruction_done plus pc_load=16'h8000 same cycle -> next FETCH_OP at 16'h8000.
REQ-026 Wrap: pc=16'hFFFF, opcode A9, mem[0000]=55 -> operand read at 16'h0000, addr_out=16'h0055, pc=16'h0001.
REQ-027 Reset asserted during FETCH_HI with mem_valid arriving one cycle later -> state VEC_LO, no capture, instruction_ready stays 0.
